// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - bus widths, load opcodes and state encodings for the memory stage
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 159;
    localparam int MS_TO_WS_BUS_WD = 152;
    localparam int MS_TO_DS_BUS_WD = 39;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    typedef enum logic [1:0] {
        MS_IDLE  = 2'd0,
        MS_WAIT  = 2'd1,
        MS_DONE  = 2'd2,
        MS_DRAIN = 2'd3
    } ms_state_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// rtl/mem_stage_load_align.sv - byte/halfword lane select and sign/zero extension of load data
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  ld_op,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[7:0];
        case (addr_lo)
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            2'd3:    byte_lane = word[31:24];
            default: byte_lane = word[7:0];
        endcase
    end

    assign half_lane = addr_lo[1] ? word[31:16] : word[15:0];

    // Unused opcodes fall back to a full-word load.
    always_comb begin
        result = word;
        case (ld_op)
            LD_B:    result = {{24{byte_lane[7]}}, byte_lane};
            LD_BU:   result = {24'd0, byte_lane};
            LD_H:    result = {{16{half_lane[15]}}, half_lane};
            LD_HU:   result = {16'd0, half_lane};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with response wait, drain on flush and bypass bus
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ws_flush_pipe
);

    logic                       ms_valid;
    ms_state_t                  state;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
    logic [31:0]                rdata_buf;

    logic        mem_req;
    logic        res_from_mem;
    logic [2:0]  ld_op;
    logic [1:0]  addr_lo;
    logic [151:0] ws_fields;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;

    logic        ms_ready_go;
    logic        ms_entry;
    logic [31:0] load_word;
    logic [31:0] load_result;
    logic [31:0] final_result;
    logic        fwd_valid;
    logic        fwd_block;

    assign mem_req      = es_bus_r[158];
    assign res_from_mem = es_bus_r[157];
    assign ld_op        = es_bus_r[156:154];
    assign addr_lo      = es_bus_r[153:152];
    assign ws_fields    = es_bus_r[151:0];
    assign gr_we        = ws_fields[69];
    assign dest         = ws_fields[68:64];
    assign alu_result   = ws_fields[63:32];

    assign ms_ready_go    = !mem_req || (state == MS_DONE)
                          || ((state == MS_WAIT) && data_sram_data_ok);
    assign ms_allowin     = (state != MS_DRAIN) && (!ms_valid || (ms_ready_go && ws_allowin));
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ws_flush_pipe;
    assign ms_entry       = ms_allowin && es_to_ms_valid && !ws_flush_pipe;

    // A response parked in DONE must win over whatever the SRAM presents later.
    assign load_word = (state == MS_DONE) ? rdata_buf : data_sram_rdata;

    load_align u_load_align (
        .word    (load_word),
        .addr_lo (addr_lo),
        .ld_op   (ld_op),
        .result  (load_result)
    );

    assign final_result = res_from_mem ? load_result : alu_result;
    assign ms_to_ws_bus = {ws_fields[151:64], final_result, ws_fields[31:0]};

    assign fwd_valid    = ms_valid && gr_we;
    assign fwd_block    = ms_valid && res_from_mem && !ms_ready_go;
    assign ms_to_ds_bus = {fwd_valid, fwd_block, dest, final_result};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ms_valid <= 1'b0;
            state    <= MS_IDLE;
        end else begin
            case (state)
                MS_WAIT: begin
                    if (data_sram_data_ok)
                        state <= (ws_allowin || ws_flush_pipe) ? MS_IDLE : MS_DONE;
                    else if (ws_flush_pipe)
                        state <= MS_DRAIN;
                end
                MS_DONE: begin
                    if (ws_allowin || ws_flush_pipe)
                        state <= MS_IDLE;
                end
                MS_DRAIN: begin
                    if (data_sram_data_ok)
                        state <= MS_IDLE;
                end
                default: state <= MS_IDLE;
            endcase

            // A new instruction overrides the retiring one's next state.
            if (ms_entry) begin
                ms_valid <= 1'b1;
                state    <= es_to_ms_bus[158] ? MS_WAIT : MS_IDLE;
            end else if (ms_allowin || ws_flush_pipe) begin
                ms_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ms_entry)
            es_bus_r <= es_to_ms_bus;
        if ((state == MS_WAIT) && data_sram_data_ok)
            rdata_buf <= data_sram_rdata;
    end

endmodule
